// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: frame states and
// the scancode bytes that the decoder treats specially.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } frameState_e;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_BRK    = 8'hF0;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR0   = 8'h00;
   localparam logic [7:0] PS2_ERR1   = 8'hFF;

   // Keyboard status/response bytes that never represent a key.
   function automatic logic isDiscard(input logic [7:0] code);
      return (code == PS2_BAT)  || (code == PS2_ACK)    ||
             (code == PS2_ECHO) || (code == PS2_RESEND) ||
             (code == PS2_ERR0) || (code == PS2_ERR1);
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line conditioning and frame receiver: synchronises and filters the
// PS/2 clock, shifts in one 11-bit frame and validates start/parity/stop.
module ps2_rx_frame #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2CLK,
   input  logic       ps2DATA,
   output logic [7:0] rxByte,
   output logic       byteValid,
   output logic       err
);
   import ps2_pkg::*;

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]   clkSync;
   logic [1:0]   dataSync;
   logic         clkS;
   logic         dataS;
   logic         filtClk;
   logic         filtClkPrev;
   logic [FW-1:0] filtCnt;
   logic         strobe;

   frameState_e  state, stateNext;
   logic [2:0]   bitCnt, bitCntNext;
   logic [7:0]   shiftReg, shiftNext;
   logic         parBit, parNext;
   logic         validNext, errNext;
   logic [TW-1:0] toCnt;
   logic         timeoutHit;

   assign clkS  = clkSync[1];
   assign dataS = dataSync[1];

   // Two-flop synchronisers; idle PS/2 lines are high, so reset to 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clkSync  <= 2'b11;
         dataSync <= 2'b11;
      end else begin
         clkSync  <= {clkSync[0], ps2CLK};
         dataSync <= {dataSync[0], ps2DATA};
      end
   end

   // The filtered clock only follows the line after FILTER_LEN consecutive
   // disagreeing samples, so short glitches never produce a strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filtClk     <= 1'b1;
         filtClkPrev <= 1'b1;
         filtCnt     <= '0;
      end else begin
         filtClkPrev <= filtClk;
         if (clkS != filtClk) begin
            if (filtCnt == FW'(FILTER_LEN - 1)) begin
               filtClk <= clkS;
               filtCnt <= '0;
            end else begin
               filtCnt <= filtCnt + FW'(1);
            end
         end else begin
            filtCnt <= '0;
         end
      end
   end

   assign strobe = filtClkPrev & ~filtClk;

   // A strobe in the terminal-count cycle wins, so the timeout is masked by it.
   assign timeoutHit = (state != IDLE) && !strobe &&
                       (toCnt == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      stateNext  = state;
      bitCntNext = bitCnt;
      shiftNext  = shiftReg;
      parNext    = parBit;
      validNext  = 1'b0;
      errNext    = 1'b0;
      if (strobe) begin
         case (state)
            IDLE: begin
               if (!dataS) begin
                  stateNext  = DATA;
                  bitCntNext = 3'd0;
               end
            end
            DATA: begin
               shiftNext = {dataS, shiftReg[7:1]};
               if (bitCnt == 3'd7) begin
                  stateNext = PARITY;
               end else begin
                  bitCntNext = bitCnt + 3'd1;
               end
            end
            PARITY: begin
               parNext   = dataS;
               stateNext = STOP;
            end
            STOP: begin
               if (dataS && (^{shiftReg, parBit})) begin
                  validNext = 1'b1;
               end else begin
                  errNext = 1'b1;
               end
               stateNext = IDLE;
            end
            default: stateNext = IDLE;
         endcase
      end else if (timeoutHit) begin
         stateNext = IDLE;
         errNext   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bitCnt    <= 3'd0;
         shiftReg  <= 8'h00;
         parBit    <= 1'b0;
         byteValid <= 1'b0;
         err       <= 1'b0;
         toCnt     <= '0;
      end else begin
         state     <= stateNext;
         bitCnt    <= bitCntNext;
         shiftReg  <= shiftNext;
         parBit    <= parNext;
         byteValid <= validNext;
         err       <= errNext;
         if ((state == IDLE) || strobe || timeoutHit) begin
            toCnt <= '0;
         end else begin
            toCnt <= toCnt + TW'(1);
         end
      end
   end

   assign rxByte = shiftReg;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: strips E0/F0 prefixes from received bytes and
// emits one-cycle make/break events with a held {extended, code} value.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2CLK,
   input  logic       ps2DATA,
   output logic [8:0] pressedKey,
   output logic       pressed,
   output logic       released,
   output logic       frameErr
);
   import ps2_pkg::*;

   logic [7:0] rxByte;
   logic       byteValid;
   logic       rxErr;
   logic       ext;
   logic       brk;

   ps2_rx_frame #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2CLK   (ps2CLK),
      .ps2DATA  (ps2DATA),
      .rxByte   (rxByte),
      .byteValid(byteValid),
      .err      (rxErr)
   );

   // pressedKey only changes on a real key event so the slow consumer can
   // sample it at leisure; a broken frame also abandons any pending prefix.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pressedKey <= 9'h000;
         pressed    <= 1'b0;
         released   <= 1'b0;
         frameErr   <= 1'b0;
         ext        <= 1'b0;
         brk        <= 1'b0;
      end else begin
         pressed  <= 1'b0;
         released <= 1'b0;
         frameErr <= rxErr;
         if (rxErr) begin
            ext <= 1'b0;
            brk <= 1'b0;
         end else if (byteValid) begin
            if (rxByte == PS2_EXT) begin
               ext <= 1'b1;
            end else if (rxByte == PS2_BRK) begin
               brk <= 1'b1;
            end else if (isDiscard(rxByte)) begin
               ext <= 1'b0;
               brk <= 1'b0;
            end else begin
               pressedKey <= {ext, rxByte};
               pressed    <= ~brk;
               released   <= brk;
               ext        <= 1'b0;
               brk        <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed PS/2 frames push expected
// events into a queue and an independent monitor checks every output pulse.
module tb_ps2_key_decoder;

   localparam int TB_FILTER  = 8;
   localparam int TB_TIMEOUT = 2000;
   localparam int HALF       = 40;
   localparam int GAP        = 200;

   localparam logic [2:0] EV_PRESS   = 3'b001;
   localparam logic [2:0] EV_RELEASE = 3'b010;
   localparam logic [2:0] EV_ERR     = 3'b100;

   typedef struct {
      logic [2:0] kind;
      logic [8:0] key;
   } event_t;

   logic       clk;
   logic       rst_n;
   logic       ps2CLK;
   logic       ps2DATA;
   logic [8:0] pressedKey;
   logic       pressed;
   logic       released;
   logic       frameErr;

   event_t expQ[$];
   int     checks   = 0;
   int     failures = 0;

   ps2_key_decoder #(
      .FILTER_LEN    (TB_FILTER),
      .TIMEOUT_CYCLES(TB_TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ps2CLK    (ps2CLK),
      .ps2DATA   (ps2DATA),
      .pressedKey(pressedKey),
      .pressed   (pressed),
      .released  (released),
      .frameErr  (frameErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic expectEvent(input logic [2:0] kind, input logic [8:0] key);
      event_t e;
      e.kind = kind;
      e.key  = key;
      expQ.push_back(e);
   endtask

   task automatic sendBit(input logic b);
      ps2DATA = b;
      repeat (HALF) @(negedge clk);
      ps2CLK = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2CLK = 1'b1;
   endtask

   // Full 11-bit frame; badPar flips the odd-parity bit.
   task automatic applyStimulus(input logic [7:0] code, input logic badPar);
      logic par;
      par = (~^code) ^ badPar;
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) sendBit(code[i]);
      sendBit(par);
      sendBit(1'b1);
      ps2DATA = 1'b1;
      repeat (GAP) @(negedge clk);
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput({"drain_", name}, expQ.size(), 0);
   endtask

   // Monitor: every output pulse must match the head of the scoreboard.
   always @(negedge clk) begin : monitor
      logic [2:0] kindBits;
      event_t     e;
      if (rst_n && (pressed || released || frameErr)) begin
         kindBits = {frameErr, released, pressed};
         if (expQ.size() == 0) begin
            checkOutput("unexpectedEvent", int'(kindBits), 0);
         end else begin
            e = expQ.pop_front();
            checkOutput("evKind", int'(kindBits), int'(e.kind));
            if (e.kind != EV_ERR) checkOutput("evKey", int'(pressedKey), int'(e.key));
         end
      end
   end

   initial begin : watchdog
      #5ms;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n   = 1'b1;
      ps2CLK  = 1'b1;
      ps2DATA = 1'b1;
      #2 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("rstKey", int'(pressedKey), 0);
      checkOutput("rstPressed", int'(pressed), 0);
      checkOutput("rstReleased", int'(released), 0);
      checkOutput("rstFrameErr", int'(frameErr), 0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      $display("[TB] make code 0x1C");
      expectEvent(EV_PRESS, 9'h01C);
      applyStimulus(8'h1C, 1'b0);
      waitDrain("make1C");
      repeat (1000) @(negedge clk);
      checkOutput("holdKey", int'(pressedKey), 9'h01C);

      $display("[TB] extended break E0 F0 75, then 29");
      expectEvent(EV_RELEASE, 9'h175);
      applyStimulus(8'hE0, 1'b0);
      applyStimulus(8'hF0, 1'b0);
      applyStimulus(8'h75, 1'b0);
      waitDrain("break175");
      expectEvent(EV_PRESS, 9'h029);
      applyStimulus(8'h29, 1'b0);
      waitDrain("make29");

      $display("[TB] parity error then recovery");
      expectEvent(EV_ERR, 9'h000);
      applyStimulus(8'h1C, 1'b1);
      waitDrain("parityErr");
      checkOutput("keyAfterErr", int'(pressedKey), 9'h029);
      expectEvent(EV_PRESS, 9'h01C);
      applyStimulus(8'h1C, 1'b0);
      waitDrain("recover1C");

      $display("[TB] mid-frame timeout then 0x5A");
      expectEvent(EV_ERR, 9'h000);
      sendBit(1'b0);
      for (int i = 0; i < 5; i++) sendBit(i[0]);
      ps2DATA = 1'b1;
      repeat (TB_TIMEOUT + 100) @(negedge clk);
      waitDrain("timeout");
      expectEvent(EV_PRESS, 9'h05A);
      applyStimulus(8'h5A, 1'b0);
      waitDrain("make5A");

      $display("[TB] clock glitch then BAT byte");
      ps2DATA = 1'b0;
      ps2CLK  = 1'b0;
      repeat (3) @(negedge clk);
      ps2CLK  = 1'b1;
      ps2DATA = 1'b1;
      repeat (50) @(negedge clk);
      applyStimulus(8'hAA, 1'b0);
      waitDrain("batDiscard");
      checkOutput("keyAfterBat", int'(pressedKey), 9'h05A);

      $display("[TB] E0 then reset mid-frame, then 0x75");
      applyStimulus(8'hE0, 1'b0);
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstKey", int'(pressedKey), 0);
      checkOutput("midRstPressed", int'(pressed), 0);
      checkOutput("midRstReleased", int'(released), 0);
      checkOutput("midRstFrameErr", int'(frameErr), 0);
      ps2CLK  = 1'b1;
      ps2DATA = 1'b1;
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      expectEvent(EV_PRESS, 9'h075);
      applyStimulus(8'h75, 1'b0);
      waitDrain("make75");

      repeat (200) @(negedge clk);
      checkOutput("queueEmpty", expQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
